// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
// Responder end of the CPU load/store interface. It accepts one request at a
// time, waits LATENCY cycles, then performs an RV32I-sized access to local
// word storage. The read data or the fault flag is returned over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I size code (lb/lh/lw/lbu/lhu, sb/sh/sw)
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  extended load data (0 for stores/faults), fault flag
module lsu_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic        DIRECT = (LATENCY <= 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [DEPTH_WORDS-1:0][31:0] mem_q;

  // Access operands: with LATENCY=1 the access happens on the accept edge, so
  // the live request inputs are used instead of the latched copies.
  logic        acc_write;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  logic [31:0] off_d;
  logic [1:0]  lane_d;
  logic [AW-1:0] widx_d;
  logic [31:0] word_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic        legal_d;
  logic        misalign_d;
  logic        oor_d;
  logic        err_d;
  logic [31:0] rdata_d;
  logic [31:0] wmask_d;
  logic [31:0] wdat_d;
  logic [31:0] merged_d;
  logic        commit_d;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = wr_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    off_d  = acc_addr - BASE_ADDR;
    lane_d = off_d[1:0];
    widx_d = off_d[AW+1:2];
    word_d = mem_q[widx_d];
    byte_d = word_d[{lane_d, 3'b000} +: 8];
    half_d = lane_d[1] ? word_d[31:16] : word_d[15:0];

    // Addresses below BASE_ADDR wrap to huge offsets and fail this check too.
    oor_d = {2'b00, off_d[31:2]} >= 32'(DEPTH_WORDS);

    if (acc_write) begin
      legal_d = (acc_f3 == 3'd0) || (acc_f3 == 3'd1) || (acc_f3 == 3'd2);
    end else begin
      legal_d = (acc_f3 == 3'd0) || (acc_f3 == 3'd1) || (acc_f3 == 3'd2) ||
                (acc_f3 == 3'd4) || (acc_f3 == 3'd5);
    end

    misalign_d = ((acc_f3[1:0] == 2'd1) && lane_d[0]) ||
                 ((acc_f3[1:0] == 2'd2) && (lane_d != 2'd0));

    err_d = oor_d || misalign_d || !legal_d;

    rdata_d = '0;
    if (!err_d && !acc_write) begin
      case (acc_f3)
        3'd0:    rdata_d = {{24{byte_d[7]}}, byte_d};
        3'd1:    rdata_d = {{16{half_d[15]}}, half_d};
        3'd2:    rdata_d = word_d;
        3'd4:    rdata_d = {24'h000000, byte_d};
        3'd5:    rdata_d = {16'h0000, half_d};
        default: rdata_d = '0;
      endcase
    end

    // Stores replicate the data across lanes and keep only the addressed bytes.
    case (acc_f3[1:0])
      2'd0: begin
        wdat_d  = {4{acc_wdata[7:0]}};
        wmask_d = 32'h0000_00FF << {lane_d, 3'b000};
      end
      2'd1: begin
        wdat_d  = {2{acc_wdata[15:0]}};
        wmask_d = lane_d[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      default: begin
        wdat_d  = acc_wdata;
        wmask_d = '1;
      end
    endcase
    merged_d = (word_d & ~wmask_d) | (wdat_d & wmask_d);

    commit_d = ((state_q == S_IDLE) && req_valid && DIRECT) ||
               ((state_q == S_WAIT) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            cnt_q       <= 4'(LATENCY - 1);
            state_q     <= DIRECT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // The access and its write land on the edge that enters RESP.
      if (commit_d) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= rdata_d;
        resp_err_q   <= err_d;
        if (acc_write && !err_d) begin
          mem_q[widx_d] <= merged_d;
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Testbench for lsu_mem_responder: directed scenarios followed by random
// load/store traffic, checked against a byte-addressed reference memory.
module tb_lsu_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec;
  int n_err;

  logic [7:0] mb [NBYTES];

  lsu_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;
  endfunction

  // Reference: memory is a flat byte array; accesses are n consecutive bytes.
  function automatic void model(input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    logic [31:0] off;
    logic [31:0] v;
    logic        legal;
    int          n;
    off = a - BASE;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    err = !legal || (off >= NBYTES) || ((off % 32'(n)) != 32'd0);
    rd = 32'h0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[int'(off) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  // Starts and ends just after a falling edge.
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] rd0;
    logic        er0;
    int          lat;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    model(w, f3, a, wd, exp_rd, exp_err);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    got_rd  = resp_rdata;
    got_err = resp_err;
    chk("rdata", resp_rdata, exp_rd);
    chk("err", {31'd0, resp_err}, {31'd0, exp_err});
    rd0 = resp_rdata;
    er0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      @(negedge clk);
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, rd0);
      chk("bp_err", {31'd0, resp_err}, {31'd0, er0});
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    chk("sw10_rdata", rd, 32'h0);
    chk("sw10_err", {31'd0, er}, 32'd0);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("lw10", rd, 32'hDEADBEEF);

    txn(1'b1, 3'd2, 32'h20, 32'h80FF7F01, 0, rd, er);
    txn(1'b0, 3'd0, 32'h23, 32'h0, 0, rd, er);
    chk("lb23", rd, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h23, 32'h0, 0, rd, er);
    chk("lbu23", rd, 32'h00000080);
    txn(1'b0, 3'd1, 32'h22, 32'h0, 0, rd, er);
    chk("lh22", rd, 32'hFFFF80FF);
    txn(1'b0, 3'd5, 32'h20, 32'h0, 0, rd, er);
    chk("lhu20", rd, 32'h00007F01);

    txn(1'b1, 3'd2, 32'h30, 32'h11223344, 0, rd, er);
    txn(1'b1, 3'd0, 32'h31, 32'h000000AA, 0, rd, er);
    txn(1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
    chk("sb31", rd, 32'h1122AA44);
    txn(1'b1, 3'd1, 32'h32, 32'h0000BEEF, 0, rd, er);
    txn(1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
    chk("sh32", rd, 32'hBEEFAA44);

    txn(1'b0, 3'd2, 32'h02, 32'h0, 0, rd, er);
    chk("lw02_err", {31'd0, er}, 32'd1);
    chk("lw02_rdata", rd, 32'h0);
    txn(1'b1, 3'd2, 32'h04, 32'h55667788, 0, rd, er);
    txn(1'b1, 3'd1, 32'h05, 32'h0000FFFF, 0, rd, er);
    chk("sh05_err", {31'd0, er}, 32'd1);
    txn(1'b0, 3'd2, 32'h04, 32'h0, 0, rd, er);
    chk("sh05_unchanged", rd, 32'h55667788);
    txn(1'b0, 3'd2, 32'h400, 32'h0, 0, rd, er);
    chk("lw400_err", {31'd0, er}, 32'd1);
    txn(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er);
    chk("ld_f3_3_err", {31'd0, er}, 32'd1);

    txn(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);
    chk("bp_lw10", rd, 32'hDEADBEEF);

    // Reset during WAIT of a store: nothing responds, nothing is written.
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
    end
    txn(1'b0, 3'd2, 32'h40, 32'h0, 0, rd, er);
    chk("rstmid_lw40", rd, 32'h0);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("rst_clears_mem", rd, 32'h0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 127));
        6, 7:             a = 32'($urandom_range(0, 1023));
        8:                a = 32'(1024 + $urandom_range(0, 255));
        default:          a = $urandom;
      endcase
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), BASE + a,
          $urandom, $urandom_range(0, 3), rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
